// File: rtl/lsu_mem_master_pkg.sv
// -----------------------------------------------------------------------------
// lsu_mem_master_pkg
//   Shared types for the load/store initiator:
//     ram_size_e   - access size encoding used on the data RAM interface
//                    (BYTE / HALF_WORD / WORD; the fourth encoding is illegal)
//     lsu_state_e  - controller states (IDLE, WRITE, READ, RESP)
//     size_bytes() - number of bytes touched by an access of a given size
// -----------------------------------------------------------------------------
package lsu_mem_master_pkg;

   // Same encoding as the data RAM's size_i port.
   typedef enum logic [1:0] {
      BYTE      = 2'b00,
      HALF_WORD = 2'b01,
      WORD      = 2'b10
   } ram_size_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WRITE = 2'b01,
      READ  = 2'b10,
      RESP  = 2'b11
   } lsu_state_e;

   // Illegal encodings report 4 so the range check stays conservative; they
   // are faulted separately anyway.
   function automatic logic [2:0] size_bytes(input ram_size_e size);
      case (size)
         BYTE:      return 3'd1;
         HALF_WORD: return 3'd2;
         default:   return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mem_master_req_check.sv
// -----------------------------------------------------------------------------
// lsu_req_check
//   Purely combinational request screening.
//   Ports:
//     addr_i         byte address of the request
//     size_i         access size
//     range_fault_o  last byte of the access lies at or beyond MEM_BYTES
//     illegal_size_o size encoding is not BYTE / HALF_WORD / WORD
//     misaligned_o   HALF_WORD on an odd address or WORD not 4-byte aligned
// -----------------------------------------------------------------------------
module lsu_req_check
   import lsu_mem_master_pkg::*;
#(
   parameter int unsigned MEM_SIZE = 4096
) (
   input  logic [31:0] addr_i,
   input  ram_size_e   size_i,
   output logic        range_fault_o,
   output logic        illegal_size_o,
   output logic        misaligned_o
);

   localparam logic [32:0] MEM_BYTES = 33'(4 * MEM_SIZE);

   // 33-bit sum so an address near 0xFFFFFFFF faults instead of wrapping.
   logic [32:0] last_byte;

   always_comb begin
      last_byte      = {1'b0, addr_i} + {30'b0, size_bytes(size_i)} - 33'd1;
      range_fault_o  = (last_byte >= MEM_BYTES);
      illegal_size_o = !((size_i == BYTE) || (size_i == HALF_WORD) || (size_i == WORD));
      case (size_i)
         HALF_WORD: misaligned_o = addr_i[0];
         WORD:      misaligned_o = |addr_i[1:0];
         default:   misaligned_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// -----------------------------------------------------------------------------
// lsu_mem_master
//   Load/store initiator between the execute stage and the data RAM. Takes one
//   request at a time, screens it, performs a single-cycle RAM write or read,
//   and returns one response.
//
//   Configuration macro: MISALIGN_TRAP_EN
//     defined   - misaligned HALF_WORD/WORD accesses fault with
//                 rsp_misaligned_o=1 (takes priority over a range fault)
//     undefined - misaligned accesses go to the byte-addressed RAM unchanged;
//                 rsp_misaligned_o is tied 0
//
//   Ports:
//     clk_i, rst_ni               clock, async active-low reset
//     req_valid_i / req_ready_o   request handshake (ready only in IDLE)
//     req_addr_i, req_we_i, req_size_i, req_unsigned_i, req_wdata_i
//                                 request payload
//     rsp_valid_o / rsp_ready_i   response handshake
//     rsp_rdata_o                 load data (0 for stores and faults)
//     rsp_err_o                   out-of-range or illegal-size fault
//     rsp_misaligned_o            misaligned fault
//     mem_*_o, mem_rdata_i        RAM interface (combinational read)
//     busy_o                      controller not in IDLE
// -----------------------------------------------------------------------------
module lsu_mem_master
   import lsu_mem_master_pkg::*;
#(
   parameter int unsigned MEM_SIZE = 4096
) (
   input  logic        clk_i,
   input  logic        rst_ni,

   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_addr_i,
   input  logic        req_we_i,
   input  ram_size_e   req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_wdata_i,

   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        rsp_misaligned_o,

   output logic [31:0] mem_address_o,
   output ram_size_e   mem_size_o,
   output logic        mem_unsigned_o,
   output logic [31:0] mem_data_o,
   output logic        mem_wr_enable_o,
   input  logic [31:0] mem_rdata_i,

   output logic        busy_o
);

   lsu_state_e  state_q,     state_d;
   logic [31:0] addr_q,      addr_d;
   logic        we_q,        we_d;
   ram_size_e   size_q,      size_d;
   logic        unsigned_q,  unsigned_d;
   logic [31:0] wdata_q,     wdata_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q,   rsp_err_d;
   logic        rsp_mis_q,   rsp_mis_d;

   logic chk_range;
   logic chk_illegal;
   logic chk_misaligned;
   logic mis_fault;
   logic err_fault;

   // Screening looks at the live request so the decision is made in the
   // accept cycle.
   lsu_req_check #(
      .MEM_SIZE (MEM_SIZE)
   ) u_req_check (
      .addr_i         (req_addr_i),
      .size_i         (req_size_i),
      .range_fault_o  (chk_range),
      .illegal_size_o (chk_illegal),
      .misaligned_o   (chk_misaligned)
   );

`ifdef MISALIGN_TRAP_EN
   assign mis_fault = chk_misaligned;
`else
   logic unused_misaligned;
   assign unused_misaligned = chk_misaligned;
   assign mis_fault         = 1'b0;
`endif

   // A misaligned trap suppresses the access-fault report.
   assign err_fault = (chk_range | chk_illegal) & ~mis_fault;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      we_d        = we_q;
      size_d      = size_q;
      unsigned_d  = unsigned_q;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      rsp_mis_d   = rsp_mis_q;

      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               addr_d     = req_addr_i;
               we_d       = req_we_i;
               size_d     = req_size_i;
               unsigned_d = req_unsigned_i;
               wdata_d    = req_wdata_i;
               if (mis_fault || err_fault) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = 32'h0;
                  rsp_err_d   = err_fault;
                  rsp_mis_d   = mis_fault;
               end else begin
                  state_d = req_we_i ? WRITE : READ;
               end
            end
         end
         WRITE: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 32'h0;
            rsp_err_d   = 1'b0;
            rsp_mis_d   = 1'b0;
         end
         READ: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = mem_rdata_i;
            rsp_err_d   = 1'b0;
            rsp_mis_d   = 1'b0;
         end
         RESP: begin
            if (rsp_ready_i) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               rsp_rdata_d = 32'h0;
               rsp_err_d   = 1'b0;
               rsp_mis_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         addr_q      <= 32'h0;
         we_q        <= 1'b0;
         size_q      <= WORD;
         unsigned_q  <= 1'b0;
         wdata_q     <= 32'h0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
         rsp_mis_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         size_q      <= size_d;
         unsigned_q  <= unsigned_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         rsp_mis_q   <= rsp_mis_d;
      end
   end

   // Write enable comes straight from the state register so an async reset
   // kills it before the next edge can write the RAM.
   assign mem_wr_enable_o  = (state_q == WRITE);
   assign req_ready_o      = (state_q == IDLE);
   assign busy_o           = (state_q != IDLE);

   assign mem_address_o    = addr_q;
   assign mem_size_o       = size_q;
   assign mem_unsigned_o   = unsigned_q;
   assign mem_data_o       = wdata_q;

   assign rsp_valid_o      = rsp_valid_q;
   assign rsp_rdata_o      = rsp_rdata_q;
   assign rsp_err_o        = rsp_err_q;
   assign rsp_misaligned_o = rsp_mis_q;

   // we_q is kept so the latched request is complete; the state already
   // encodes the direction.
   logic unused_we;
   assign unused_we = we_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;
   import lsu_mem_master_pkg::*;

   localparam int MEM_SIZE  = 4096;
   localparam int MEM_BYTES = 4 * MEM_SIZE;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] req_addr_i;
   logic        req_we_i;
   ram_size_e   req_size_i;
   logic        req_unsigned_i;
   logic [31:0] req_wdata_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        rsp_misaligned_o;
   logic [31:0] mem_address_o;
   ram_size_e   mem_size_o;
   logic        mem_unsigned_o;
   logic [31:0] mem_data_o;
   logic        mem_wr_enable_o;
   logic [31:0] mem_rdata_i;
   logic        busy_o;

   int total = 0;
   int bad   = 0;
   int wr_pulses = 0;

   always #5 clk_i = ~clk_i;

   lsu_mem_master #(.MEM_SIZE(MEM_SIZE)) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .req_valid_i      (req_valid_i),
      .req_ready_o      (req_ready_o),
      .req_addr_i       (req_addr_i),
      .req_we_i         (req_we_i),
      .req_size_i       (req_size_i),
      .req_unsigned_i   (req_unsigned_i),
      .req_wdata_i      (req_wdata_i),
      .rsp_valid_o      (rsp_valid_o),
      .rsp_ready_i      (rsp_ready_i),
      .rsp_rdata_o      (rsp_rdata_o),
      .rsp_err_o        (rsp_err_o),
      .rsp_misaligned_o (rsp_misaligned_o),
      .mem_address_o    (mem_address_o),
      .mem_size_o       (mem_size_o),
      .mem_unsigned_o   (mem_unsigned_o),
      .mem_data_o       (mem_data_o),
      .mem_wr_enable_o  (mem_wr_enable_o),
      .mem_rdata_i      (mem_rdata_i),
      .busy_o           (busy_o)
   );

   // Byte-addressed little-endian RAM with combinational, extending read.
   logic [7:0]  ram_q [0:MEM_BYTES-1] = '{default: 8'h00};
   logic [31:0] rd_bytes;
   logic [32:0] rd_idx;

   always_comb begin
      rd_bytes = 32'h0;
      rd_idx   = 33'h0;
      for (int i = 0; i < 4; i++) begin
         rd_idx = {1'b0, mem_address_o} + 33'(i);
         if (rd_idx < 33'(MEM_BYTES)) rd_bytes[8*i +: 8] = ram_q[rd_idx[13:0]];
      end
      case (mem_size_o)
         BYTE:      mem_rdata_i = mem_unsigned_o ? {24'h0, rd_bytes[7:0]}
                                                 : {{24{rd_bytes[7]}}, rd_bytes[7:0]};
         HALF_WORD: mem_rdata_i = mem_unsigned_o ? {16'h0, rd_bytes[15:0]}
                                                 : {{16{rd_bytes[15]}}, rd_bytes[15:0]};
         default:   mem_rdata_i = rd_bytes;
      endcase
   end

   always @(posedge clk_i) begin
      if (mem_wr_enable_o) begin
         wr_pulses <= wr_pulses + 1;
         for (int i = 0; i < 4; i++) begin
            if ((i < int'(size_bytes(mem_size_o))) &&
                (({1'b0, mem_address_o} + 33'(i)) < 33'(MEM_BYTES)))
               ram_q[14'(mem_address_o + 32'(i))] <= mem_data_o[8*i +: 8];
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers (stimulus only) ----------------
   task automatic issue(input logic [31:0] a, input logic we, input ram_size_e s,
                        input logic u, input logic [31:0] d);
      req_valid_i    = 1'b1;
      req_addr_i     = a;
      req_we_i       = we;
      req_size_i     = s;
      req_unsigned_i = u;
      req_wdata_i    = d;
      @(posedge clk_i); #1;
      req_valid_i    = 1'b0;
   endtask

   // Returns cycles from accept edge to rsp_valid_o (99 if it never came).
   task automatic wait_rsp(output int cyc);
      cyc = 1;
      while (!rsp_valid_o && cyc < 20) begin
         @(posedge clk_i); #1;
         cyc++;
      end
      if (!rsp_valid_o) cyc = 99;
   endtask

   task automatic consume();
      rsp_ready_i = 1'b1;
      @(posedge clk_i); #1;
      rsp_ready_i = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_ni = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready_o); end
      total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid_o); end
      total++; if (rsp_rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata_o); end
      total++; if ({rsp_err_o, rsp_misaligned_o, busy_o, mem_wr_enable_o} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {rsp_err_o, rsp_misaligned_o, busy_o, mem_wr_enable_o}); end
      total++; if (mem_size_o !== WORD) begin bad++; $display("FAIL reset_mem_size got=%0d want=%0d", mem_size_o, WORD); end
      total++; if ({mem_address_o, mem_data_o, mem_unsigned_o} !== 65'h0) begin bad++; $display("FAIL reset_mem_regs got=%h want=0", {mem_address_o, mem_data_o, mem_unsigned_o}); end
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
   endtask

   task automatic test_store_load_word();
      int cyc; int p0;
      p0 = wr_pulses;
      issue(32'h10, 1'b1, WORD, 1'b0, 32'hDEADBEEF);
      total++; if (mem_wr_enable_o !== 1'b1 || mem_address_o !== 32'h10) begin bad++; $display("FAIL sw_write_cycle got we=%b addr=%h want we=1 addr=00000010", mem_wr_enable_o, mem_address_o); end
      wait_rsp(cyc);
      total++; if (cyc !== 2) begin bad++; $display("FAIL sw_latency got=%0d want=2", cyc); end
      total++; if (wr_pulses - p0 !== 1) begin bad++; $display("FAIL sw_pulse_count got=%0d want=1", wr_pulses - p0); end
      total++; if (rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h0) begin bad++; $display("FAIL sw_rsp got err=%b rdata=%h want err=0 rdata=0", rsp_err_o, rsp_rdata_o); end
      total++; if (mem_wr_enable_o !== 1'b0 || mem_address_o !== 32'h10) begin bad++; $display("FAIL sw_after got we=%b addr=%h want we=0 addr=00000010", mem_wr_enable_o, mem_address_o); end
      consume();
      issue(32'h10, 1'b0, WORD, 1'b0, 32'h0);
      wait_rsp(cyc);
      total++; if (cyc !== 2) begin bad++; $display("FAIL lw_latency got=%0d want=2", cyc); end
      total++; if (rsp_rdata_o !== 32'hDEADBEEF || rsp_err_o !== 1'b0) begin bad++; $display("FAIL lw_rdata got=%h err=%b want=deadbeef err=0", rsp_rdata_o, rsp_err_o); end
      total++; if (wr_pulses - p0 !== 1) begin bad++; $display("FAIL lw_no_write got=%0d want=1", wr_pulses - p0); end
      consume();
   endtask

   task automatic test_byte_ext();
      int cyc;
      issue(32'h21, 1'b1, BYTE, 1'b0, 32'h00000080);
      wait_rsp(cyc); consume();
      issue(32'h21, 1'b0, BYTE, 1'b0, 32'h0);
      wait_rsp(cyc);
      total++; if (rsp_rdata_o !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_signed got=%h want=ffffff80", rsp_rdata_o); end
      consume();
      issue(32'h21, 1'b0, BYTE, 1'b1, 32'h0);
      wait_rsp(cyc);
      total++; if (rsp_rdata_o !== 32'h00000080) begin bad++; $display("FAIL lb_unsigned got=%h want=00000080", rsp_rdata_o); end
      consume();
   endtask

   task automatic test_range();
      int cyc; int p0;
      p0 = wr_pulses;
      issue(32'h3FFD, 1'b0, WORD, 1'b0, 32'h0);
      wait_rsp(cyc);
      total++; if (cyc !== 1) begin bad++; $display("FAIL range_fault_latency got=%0d want=1", cyc); end
      total++; if (rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin bad++; $display("FAIL range_lw_3ffd got err=%b rdata=%h want err=1 rdata=0", rsp_err_o, rsp_rdata_o); end
      consume();
      issue(32'h3FFD, 1'b1, WORD, 1'b0, 32'hCAFEF00D);
      wait_rsp(cyc);
      total++; if (rsp_err_o !== 1'b1 || wr_pulses !== p0) begin bad++; $display("FAIL range_sw_3ffd got err=%b pulses=%0d want err=1 pulses=%0d", rsp_err_o, wr_pulses, p0); end
      consume();
      issue(32'h3FFF, 1'b0, BYTE, 1'b0, 32'h0);
      wait_rsp(cyc);
      total++; if (rsp_err_o !== 1'b0 || cyc !== 2) begin bad++; $display("FAIL range_lb_3fff got err=%b lat=%0d want err=0 lat=2", rsp_err_o, cyc); end
      consume();
      issue(32'hFFFFFFFE, 1'b0, WORD, 1'b0, 32'h0);
      wait_rsp(cyc);
      total++; if (rsp_err_o !== 1'b1) begin bad++; $display("FAIL range_wrap got err=%b want=1", rsp_err_o); end
      consume();
      issue(32'h0, 1'b1, ram_size_e'(2'b11), 1'b0, 32'h11111111);
      wait_rsp(cyc);
      total++; if (rsp_err_o !== 1'b1 || wr_pulses !== p0) begin bad++; $display("FAIL illegal_size got err=%b pulses=%0d want err=1 pulses=%0d", rsp_err_o, wr_pulses, p0); end
      consume();
   endtask

   task automatic test_backpressure();
      int cyc; int p0;
      issue(32'h10, 1'b0, WORD, 1'b0, 32'h0);
      wait_rsp(cyc);
      p0 = wr_pulses;
      req_valid_i = 1'b1; req_addr_i = 32'h80; req_we_i = 1'b1;
      req_size_i  = WORD; req_unsigned_i = 1'b0; req_wdata_i = 32'h00000055;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk_i); #1;
         total++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hDEADBEEF || req_ready_o !== 1'b0) begin bad++; $display("FAIL hold_%0d got v=%b rdata=%h rdy=%b want v=1 rdata=deadbeef rdy=0", k, rsp_valid_o, rsp_rdata_o, req_ready_o); end
      end
      rsp_ready_i = 1'b1;
      @(posedge clk_i); #1;
      rsp_ready_i = 1'b0;
      total++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || mem_address_o !== 32'h10) begin bad++; $display("FAIL handoff got v=%b rdy=%b addr=%h want v=0 rdy=1 addr=00000010", rsp_valid_o, req_ready_o, mem_address_o); end
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      total++; if (mem_address_o !== 32'h80 || mem_wr_enable_o !== 1'b1) begin bad++; $display("FAIL second_accept got addr=%h we=%b want addr=00000080 we=1", mem_address_o, mem_wr_enable_o); end
      wait_rsp(cyc);
      total++; if (cyc !== 2 || wr_pulses - p0 !== 1) begin bad++; $display("FAIL second_rsp got lat=%0d pulses=%0d want lat=2 pulses=1", cyc, wr_pulses - p0); end
      consume();
   endtask

   task automatic test_reset_mid_write();
      int cyc; int p0;
      p0 = wr_pulses;
      issue(32'h40, 1'b1, WORD, 1'b0, 32'h12345678);
      total++; if (mem_wr_enable_o !== 1'b1) begin bad++; $display("FAIL midrst_pre got we=%b want=1", mem_wr_enable_o); end
      #2 rst_ni = 1'b0;
      #1;
      total++; if (mem_wr_enable_o !== 1'b0 || busy_o !== 1'b0 || req_ready_o !== 1'b1) begin bad++; $display("FAIL midrst_async got we=%b busy=%b rdy=%b want we=0 busy=0 rdy=1", mem_wr_enable_o, busy_o, req_ready_o); end
      total++; if (mem_address_o !== 32'h0 || mem_data_o !== 32'h0 || mem_size_o !== WORD || rsp_valid_o !== 1'b0) begin bad++; $display("FAIL midrst_regs got addr=%h data=%h size=%0d v=%b want 0/0/%0d/0", mem_address_o, mem_data_o, mem_size_o, rsp_valid_o, WORD); end
      @(posedge clk_i); #1;
      total++; if (wr_pulses !== p0) begin bad++; $display("FAIL midrst_no_write got=%0d want=%0d", wr_pulses, p0); end
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      issue(32'h40, 1'b0, WORD, 1'b0, 32'h0);
      wait_rsp(cyc);
      total++; if (rsp_rdata_o !== 32'h0 || cyc !== 2) begin bad++; $display("FAIL midrst_readback got=%h lat=%0d want=0 lat=2", rsp_rdata_o, cyc); end
      consume();
   endtask

   task automatic test_misalign();
      int cyc; int p0;
      p0 = wr_pulses;
      issue(32'h03, 1'b1, HALF_WORD, 1'b0, 32'h1234BEEF);
      wait_rsp(cyc);
`ifdef MISALIGN_TRAP_EN
      total++; if (rsp_misaligned_o !== 1'b1 || rsp_err_o !== 1'b0 || cyc !== 1) begin bad++; $display("FAIL mis_sh got mis=%b err=%b lat=%0d want mis=1 err=0 lat=1", rsp_misaligned_o, rsp_err_o, cyc); end
      total++; if (wr_pulses !== p0) begin bad++; $display("FAIL mis_no_write got=%0d want=%0d", wr_pulses, p0); end
      consume();
      issue(32'h3FFE, 1'b0, WORD, 1'b0, 32'h0);
      wait_rsp(cyc);
      total++; if (rsp_misaligned_o !== 1'b1 || rsp_err_o !== 1'b0) begin bad++; $display("FAIL mis_priority got mis=%b err=%b want mis=1 err=0", rsp_misaligned_o, rsp_err_o); end
      consume();
`else
      total++; if (rsp_misaligned_o !== 1'b0 || rsp_err_o !== 1'b0 || wr_pulses - p0 !== 1) begin bad++; $display("FAIL mis_sh_pass got mis=%b err=%b pulses=%0d want 0/0/1", rsp_misaligned_o, rsp_err_o, wr_pulses - p0); end
      consume();
      issue(32'h03, 1'b0, HALF_WORD, 1'b1, 32'h0);
      wait_rsp(cyc);
      total++; if (rsp_rdata_o !== 32'h0000BEEF) begin bad++; $display("FAIL mis_lhu got=%h want=0000beef", rsp_rdata_o); end
      consume();
      issue(32'h3FFE, 1'b0, WORD, 1'b0, 32'h0);
      wait_rsp(cyc);
      total++; if (rsp_err_o !== 1'b1 || rsp_misaligned_o !== 1'b0) begin bad++; $display("FAIL mis_range got err=%b mis=%b want err=1 mis=0", rsp_err_o, rsp_misaligned_o); end
      consume();
`endif
   endtask

   initial begin
      rst_ni         = 1'b0;
      req_valid_i    = 1'b0;
      req_addr_i     = 32'h0;
      req_we_i       = 1'b0;
      req_size_i     = WORD;
      req_unsigned_i = 1'b0;
      req_wdata_i    = 32'h0;
      rsp_ready_i    = 1'b0;

      test_reset();
      test_store_load_word();
      test_byte_ext();
      test_range();
      test_backpressure();
      test_reset_mid_write();
      test_misalign();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
